// File: rtl/aggr_par_deagg_pkg.sv
// aggr_par_deagg_pkg: descriptor layout, widths, FSM states and command record for the aggregate de-aggregator.
package aggr_par_deagg_pkg;
    localparam int PTR_NBITS  = 16;
    localparam int LEN_NBITS  = 14;
    localparam int NSUB_NBITS = 4;
    localparam int PROD_NBITS = LEN_NBITS + NSUB_NBITS;

    typedef struct packed {
        logic [PTR_NBITS-1:0]  buf_ptr;
        logic [LEN_NBITS-1:0]  len;
        logic [LEN_NBITS-1:0]  sub_len;
        logic [NSUB_NBITS-1:0] nsub;
    } aggr_par_meta_type;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} aggr_deagg_state_type;

    typedef struct packed {
        logic [PTR_NBITS-1:0]  ptr;
        logic [LEN_NBITS-1:0]  len;
        logic [NSUB_NBITS-1:0] idx;
        logic                  last;
    } aggr_deagg_cmd_type;
endpackage

// File: rtl/aggr_par_deagg_chk.sv
// aggr_par_deagg_chk: combinational descriptor validator; yields the last sub-packet length and an error flag.
module aggr_par_deagg_chk
    import aggr_par_deagg_pkg::*;
#(
    parameter int MAX_NSUB = 8
) (
    input  aggr_par_meta_type     meta,
    output logic [LEN_NBITS-1:0]  rem,
    output logic                  err
);
    logic [NSUB_NBITS-1:0] nsub_m1;
    logic [PROD_NBITS-1:0] prod;

    always_comb begin
        nsub_m1 = meta.nsub - NSUB_NBITS'(1);
        // Full-width product so an oversized sub_len cannot alias below len.
        prod    = PROD_NBITS'(nsub_m1) * PROD_NBITS'(meta.sub_len);
        rem     = meta.len - prod[LEN_NBITS-1:0];
        err     = meta.nsub == '0 || int'(meta.nsub) > MAX_NSUB || meta.len == '0 ||
                  (meta.sub_len == '0 && meta.nsub > NSUB_NBITS'(1)) ||
                  prod >= PROD_NBITS'(meta.len);
    end
endmodule

// File: rtl/aggr_par_deagg.sv
// aggr_par_deagg: pops aggregate descriptors from a show-ahead FIFO and issues one command per sub-packet.
// Defining AGGR_PAR_DEAGG_STATS_EN adds aggr_cnt/cmd_cnt statistics outputs.
module aggr_par_deagg
    import aggr_par_deagg_pkg::*;
#(
    parameter int MAX_NSUB      = 8,
    parameter int ERR_CNT_NBITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     meta_empty,
    input  aggr_par_meta_type        meta_dout,
    output logic                     meta_rd,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [PTR_NBITS-1:0]     cmd_ptr,
    output logic [LEN_NBITS-1:0]     cmd_len,
    output logic [NSUB_NBITS-1:0]    cmd_idx,
    output logic                     cmd_last,
    output logic                     busy,
    output logic [ERR_CNT_NBITS-1:0] err_cnt
`ifdef AGGR_PAR_DEAGG_STATS_EN
    ,
    output logic [31:0]              aggr_cnt,
    output logic [31:0]              cmd_cnt
`endif
);
    aggr_deagg_state_type     state_q, state_d;
    aggr_par_meta_type        meta_q, meta_d;
    aggr_deagg_cmd_type       cmd_q, cmd_d;
    logic [LEN_NBITS-1:0]     rem_q, rem_d, chk_rem;
    logic                     valid_q, valid_d, busy_q, busy_d, chk_err, fire, single, last_nx;
    logic [ERR_CNT_NBITS-1:0] err_q, err_d;
    logic [NSUB_NBITS-1:0]    idx_nx;

    aggr_par_deagg_chk #(.MAX_NSUB(MAX_NSUB)) u_chk (
        .meta (meta_q),
        .rem  (chk_rem),
        .err  (chk_err)
    );

    assign meta_rd = state_q == IDLE && !meta_empty;
    assign fire    = valid_q && cmd_ready;
    assign single  = meta_q.nsub == NSUB_NBITS'(1);
    assign idx_nx  = cmd_q.idx + NSUB_NBITS'(1);
    assign last_nx = idx_nx == meta_q.nsub - NSUB_NBITS'(1);

    always_comb begin
        state_d = state_q;
        meta_d  = meta_q;
        cmd_d   = cmd_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (!meta_empty) begin
                meta_d  = meta_dout;
                state_d = CHECK;
            end
            CHECK: if (chk_err) begin
                err_d   = &err_q ? err_q : err_q + ERR_CNT_NBITS'(1);
                state_d = IDLE;
            end else begin
                rem_d      = chk_rem;
                cmd_d.ptr  = meta_q.buf_ptr;
                cmd_d.len  = single ? meta_q.len : meta_q.sub_len;
                cmd_d.idx  = '0;
                cmd_d.last = single;
                valid_d    = 1'b1;
                state_d    = ISSUE;
            end
            ISSUE: if (fire && cmd_q.last) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end else if (fire) begin
                cmd_d.ptr  = cmd_q.ptr + PTR_NBITS'(meta_q.sub_len);
                cmd_d.idx  = idx_nx;
                cmd_d.len  = last_nx ? rem_q : meta_q.sub_len;
                cmd_d.last = last_nx;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            meta_q  <= '0;
            cmd_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            meta_q  <= meta_d;
            cmd_q   <= cmd_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_ptr   = cmd_q.ptr;
    assign cmd_len   = cmd_q.len;
    assign cmd_idx   = cmd_q.idx;
    assign cmd_last  = cmd_q.last;
    assign busy      = busy_q;
    assign err_cnt   = err_q;

`ifdef AGGR_PAR_DEAGG_STATS_EN
    logic [31:0] aggr_cnt_q, aggr_cnt_d, cmd_cnt_q, cmd_cnt_d;

    always_comb begin
        cmd_cnt_d  = cmd_cnt_q + 32'(fire);
        aggr_cnt_d = aggr_cnt_q + 32'(fire && cmd_q.last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aggr_cnt_q <= '0;
            cmd_cnt_q  <= '0;
        end else begin
            aggr_cnt_q <= aggr_cnt_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    assign aggr_cnt = aggr_cnt_q;
    assign cmd_cnt  = cmd_cnt_q;
`endif
endmodule

// File: tb/tb_aggr_par_deagg.sv
// tb_aggr_par_deagg: table vectors, corner sequences and random descriptors checked against a queue-based model.
`timescale 1ns/1ps
module tb_aggr_par_deagg;
    import aggr_par_deagg_pkg::*;

    logic              clk = 1'b0, rst_n = 1'b0, meta_empty = 1'b1, cmd_ready = 1'b0;
    aggr_par_meta_type meta_dout = '0;
    logic              meta_rd, cmd_valid, cmd_last, busy;
    logic [15:0]       cmd_ptr, err_cnt;
    logic [13:0]       cmd_len;
    logic [3:0]        cmd_idx;
`ifdef AGGR_PAR_DEAGG_STATS_EN
    logic [31:0]       aggr_cnt, cmd_cnt;
`endif

    always #5 clk = ~clk;

    aggr_par_deagg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .meta_empty (meta_empty),
        .meta_dout  (meta_dout),
        .meta_rd    (meta_rd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ptr    (cmd_ptr),
        .cmd_len    (cmd_len),
        .cmd_idx    (cmd_idx),
        .cmd_last   (cmd_last),
        .busy       (busy),
        .err_cnt    (err_cnt)
`ifdef AGGR_PAR_DEAGG_STATS_EN
        ,
        .aggr_cnt   (aggr_cnt),
        .cmd_cnt    (cmd_cnt)
`endif
    );

    aggr_par_meta_type  pend[$], fifo[$];
    aggr_deagg_cmd_type got[$], exp_q[$];
    int  n_pass = 0, n_total = 0, pops = 0, empty_pops = 0, cyc = 0, pop_cyc = 0, valid_cyc = 0;
    int  pend_rd = 0, exp_err = 0;
    logic pop_req = 1'b0;

    // FIFO model: pops and pushes take effect just after the clock edge that consumes them.
    always @(posedge clk) begin
        #1;
        if (!rst_n) fifo.delete();
        else if (pop_req && fifo.size() > 0) fifo.delete(0);
        while (pend_rd < pend.size()) begin
            fifo.push_back(pend[pend_rd]);
            pend_rd++;
        end
        meta_empty = fifo.size() == 0;
        meta_dout  = fifo.size() > 0 ? fifo[0] : '0;
    end

    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        pop_req = meta_rd;
        if (meta_rd) begin
            pops++;
            pop_cyc = cyc;
            if (meta_empty) empty_pops++;
        end
        if (cmd_valid && !valid_prev) valid_cyc = cyc;
        valid_prev = cmd_valid;
        if (cmd_valid && cmd_ready) got.push_back('{cmd_ptr, cmd_len, cmd_idx, cmd_last});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: expand a descriptor into its command list straight from the splitting rules.
    function automatic void model(input aggr_par_meta_type m);
        int n = int'(m.nsub), sl = int'(m.sub_len), l = int'(m.len), prod;
        prod = (n - 1) * sl;
        if (n == 0 || n > 8 || l == 0 || (sl == 0 && n > 1) || prod >= l) begin
            exp_err++;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_q.push_back('{ptr: 16'(int'(m.buf_ptr) + i * sl),
                              len: (i == n - 1) ? 14'(l - prod) : 14'(sl),
                              idx: 4'(i), last: i == n - 1});
    endfunction

    function automatic bit idle();
        return pend_rd == pend.size() && fifo.size() == 0 && !busy && !cmd_valid && !meta_rd;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle() && n < 3000);
        check({name, " done"}, 64'(n < 3000), 64'(1));
    endtask

    task automatic cmp_stream(input string name, input int gb, input int eb);
        check({name, " count"}, 64'(got.size() - gb), 64'(exp_q.size() - eb));
        for (int i = 0; i < exp_q.size() - eb && gb + i < got.size(); i++)
            check($sformatf("%s cmd%0d", name, i), 64'(got[gb + i]), 64'(exp_q[eb + i]));
    endtask

    typedef struct {
        aggr_par_meta_type m;
        int                n_cmd;
        logic [15:0]       last_ptr;
        logic [13:0]       last_len;
        bit                err;
    } vec_t;
    vec_t vec[12];

    initial begin
        #3_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        aggr_par_meta_type  basic, m;
        aggr_deagg_cmd_type snap;
        int gb, eb, e0, p0, n;
        basic = '{16'h0100, 14'd1000, 14'd256, 4'd4};
        vec[0]  = '{basic,                                   4, 16'h0400, 14'd232,  0};
        vec[1]  = '{'{16'hFF80, 14'd200,   14'd128,   4'd2}, 2, 16'h0000, 14'd72,   0};
        vec[2]  = '{'{16'h0000, 14'd500,   14'd256,   4'd3}, 0, 16'h0,    14'd0,    1};
        vec[3]  = '{'{16'h0000, 14'd100,   14'd10,    4'd0}, 0, 16'h0,    14'd0,    1};
        vec[4]  = '{'{16'h0000, 14'd100,   14'd10,    4'd9}, 0, 16'h0,    14'd0,    1};
        vec[5]  = '{'{16'h0000, 14'd0,     14'd10,    4'd1}, 0, 16'h0,    14'd0,    1};
        vec[6]  = '{'{16'h0000, 14'd10,    14'd0,     4'd2}, 0, 16'h0,    14'd0,    1};
        vec[7]  = '{'{16'h1234, 14'd77,    14'd0,     4'd1}, 1, 16'h1234, 14'd77,   0};
        vec[8]  = '{'{16'h0000, 14'd512,   14'd256,   4'd3}, 0, 16'h0,    14'd0,    1};
        vec[9]  = '{'{16'h1000, 14'd16383, 14'd2047,  4'd8}, 8, 16'h47F9, 14'd2054, 0};
        vec[10] = '{'{16'h0000, 14'd16383, 14'd16383, 4'd8}, 0, 16'h0,    14'd0,    1};
        vec[11] = '{'{16'h0000, 14'd300,   14'd30,    4'd15}, 0, 16'h0,   14'd0,    1};

        repeat (3) @(negedge clk);
        check("rst cmd_valid", cmd_valid, 0);
        check("rst busy", busy, 0);
        check("rst err_cnt", err_cnt, 0);
        check("rst meta_rd", meta_rd, 0);
        check("rst cmd fields", {cmd_ptr, cmd_len, cmd_idx, cmd_last}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmd_ready = 1'b1;

        for (int v = 0; v < 12; v++) begin
            gb = got.size(); eb = exp_q.size(); e0 = err_cnt; p0 = pops;
            model(vec[v].m);
            pend.push_back(vec[v].m);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d ncmd", v), 64'(got.size() - gb), 64'(vec[v].n_cmd));
            check($sformatf("vec%0d err", v), 64'(int'(err_cnt) - e0), 64'(vec[v].err));
            check($sformatf("vec%0d pops", v), 64'(pops - p0), 64'(1));
            if (vec[v].n_cmd > 0 && got.size() > gb) begin
                check($sformatf("vec%0d last", v), {got[$].ptr, got[$].len, got[$].last},
                      {vec[v].last_ptr, vec[v].last_len, 1'b1});
                check($sformatf("vec%0d latency", v), 64'(valid_cyc - pop_cyc), 64'(2));
            end
            cmp_stream($sformatf("vec%0d", v), gb, eb);
        end

        gb = got.size(); eb = exp_q.size();
        model(basic);
        pend.push_back(basic);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(cmd_valid && cmd_idx == 4'd1) && n < 100);
        cmd_ready = 1'b0;
        snap = '{cmd_ptr, cmd_len, cmd_idx, cmd_last};
        check("bp at idx1", snap, {16'h0200, 14'd256, 4'd1, 1'b0});
        repeat (5) begin
            @(posedge clk); #1;
            check("bp hold", {cmd_valid, cmd_ptr, cmd_len, cmd_idx, cmd_last}, {1'b1, snap});
        end
        cmd_ready = 1'b1;
        wait_idle("bp");
        cmp_stream("bp", gb, eb);

        gb = got.size(); eb = exp_q.size(); p0 = pops;
        for (int i = 1; i <= 3; i++) begin
            m = '{16'(i * 16), 14'(4 + i), 14'd0, 4'd1};
            model(m);
            pend.push_back(m);
        end
        wait_idle("b2b");
        check("b2b pops", 64'(pops - p0), 64'(3));
        cmp_stream("b2b", gb, eb);
        check("b2b empty pops", 64'(empty_pops), 64'(0));

        pend.push_back(basic);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(cmd_valid && cmd_idx == 4'd2) && n < 100);
        check("pre-rst err_cnt nonzero", 64'(err_cnt != 0), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid-rst cmd_valid", cmd_valid, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst err_cnt", err_cnt, 0);
        check("mid-rst cmd_idx", cmd_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 0;
        gb = got.size(); eb = exp_q.size();
        model(basic);
        pend.push_back(basic);
        wait_idle("post-rst");
        cmp_stream("post-rst", gb, eb);
        check("post-rst err_cnt", err_cnt, 0);

        gb = got.size(); eb = exp_q.size();
        for (int i = 0; i < 40; i++) begin
            m = '{16'($urandom), 14'($urandom_range(0, 3500)), 14'($urandom_range(0, 400)),
                  4'($urandom_range(0, 10))};
            model(m);
            pend.push_back(m);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            cmd_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            n++;
        end while (!idle() && n < 8000);
        check("rand done", 64'(n < 8000), 64'(1));
        cmp_stream("rand", gb, eb);
        check("rand err_cnt", err_cnt, 16'(exp_err));
        check("rand empty pops", 64'(empty_pops), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/aggr_par_deagg.md
Name: aggr_par_deagg

Overview:
- Drains aggr_par_meta_type descriptors from the read side of the aggregation-parser metadata FIFO (show-ahead, registered dout).
- Splits each aggregate into per-sub-packet commands (buffer pointer, length, index) on a valid/ready interface to the buffer-read/egress engine.
- Malformed descriptors are validated, dropped and counted.

Parameters:
- MAX_NSUB, 8: largest legal sub-packet count; nsub > MAX_NSUB is an error.
- ERR_CNT_NBITS, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock
- `RESET_SIG  in  1  reset, asynchronous, active-low
- meta_empty  in  1  FIFO empty; meta_dout is valid whenever low
- meta_dout  in  aggr_par_meta_type  FIFO head entry
- meta_rd  out  1  pop strobe, one cycle per entry
- cmd_valid  out  1  command valid
- cmd_ready  in  1  downstream accept
- cmd_ptr  out  PTR_NBITS  sub-packet start pointer
- cmd_len  out  LEN_NBITS  sub-packet length in bytes
- cmd_idx  out  NSUB_NBITS  sub-packet index within the aggregate
- cmd_last  out  1  final sub-packet of the aggregate
- busy  out  1  FSM not IDLE
- err_cnt  out  ERR_CNT_NBITS  dropped-descriptor count, saturating

Behaviour:
- Descriptor fields (defined in meta_package): buf_ptr[PTR_NBITS], len[LEN_NBITS], sub_len[LEN_NBITS], nsub[NSUB_NBITS].
  - Sub-packets 0..nsub-2 are sub_len bytes each.
  - Last sub-packet length: rem = len - (nsub-1)*sub_len.
- Reset values: FSM IDLE, meta_rd=0, cmd_valid=0, cmd_ptr/len/idx=0, cmd_last=0, busy=0, err_cnt=0.
- All outputs are registered except meta_rd, which is combinational from state and meta_empty.
- FSM IDLE:
  - If ~meta_empty: assert meta_rd the same cycle, latch meta_dout into working registers, go CHECK.
  - Never pops when meta_empty=1.
- FSM CHECK (1 cycle):
  - Register prod = (nsub-1)*sub_len at full width, no truncation.
  - Error if nsub==0, nsub>MAX_NSUB, len==0, sub_len==0 with nsub>1, or prod>=len.
  - On error: err_cnt += 1, saturating at all-ones; go IDLE; no command is issued.
  - Otherwise: load cmd_ptr=buf_ptr, cmd_idx=0, cmd_len=(nsub==1 ? len : sub_len), cmd_last=(nsub==1); set cmd_valid; go ISSUE.
- FSM ISSUE:
  - cmd_valid=1.
  - While ~cmd_ready: all cmd_* outputs hold stable.
  - On valid&ready with ~cmd_last: cmd_ptr += sub_len (wraps modulo 2^PTR_NBITS); cmd_idx += 1; cmd_len=rem when the new idx==nsub-1, else sub_len; cmd_last set accordingly.
  - On valid&ready with cmd_last: cmd_valid=0, go IDLE.
- Throughput:
  - 1 command/cycle within an aggregate.
  - 2 idle cycles between aggregates (IDLE pop, CHECK).
  - FIFO pop to first cmd_valid latency = 2 cycles.
- Pop protocol: at most one meta_rd per aggregate, so a FIFO read-when-empty cannot occur.
- Reset asserted mid-operation: immediate async return to reset values. The in-flight descriptor is discarded; the FIFO shares the reset and clears too.
- Widths: cmd_idx never exceeds MAX_NSUB-1; rem always fits in LEN_NBITS after a passing check.

Optional Feature:
- Macro: AGGR_PAR_DEAGG_STATS_EN.
- Defined:
  - Adds outputs aggr_cnt[31:0] (aggregates fully issued, incremented on the cmd_last handshake).
  - Adds cmd_cnt[31:0] (commands accepted).
  - Both wrap, reset to 0.
- Undefined: neither port nor its counter logic exists.

Decomposition:
- meta_package additions:
  - aggr_par_meta_type field layout.
  - Constants PTR_NBITS=16, LEN_NBITS=14, NSUB_NBITS=4.
  - FSM enum aggr_deagg_state_type {IDLE, CHECK, ISSUE}.
  - Command struct aggr_deagg_cmd_type.
- One sub-module is natural: aggr_par_deagg_chk, combinational descriptor validator computing prod/rem/error, registered by the parent in CHECK.

Test Plan:
- Basic split: buf_ptr=0x0100, len=1000, sub_len=256, nsub=4, cmd_ready=1 -> commands (0x0100,256,0), (0x0200,256,1), (0x0300,256,2), (0x0400,232,3,last); one meta_rd pulse; first cmd_valid 2 cycles after the pop.
- Pointer wrap: buf_ptr=0xFF80, len=200, sub_len=128, nsub=2 -> (0xFF80,128,0), (0x0000,72,1,last).
- Errors: (len=500, sub_len=256, nsub=3), then nsub=0, then nsub=9 -> no cmd_valid, err_cnt=3, each entry popped exactly once.
- Backpressure: hold cmd_ready=0 for 5 cycles on idx=1 of the basic case -> cmd_ptr/len/idx/last unchanged, then the sequence resumes with no skip or duplicate.
- Back-to-back: 3 valid single-sub (nsub=1) entries preloaded -> each yields one cmd with cmd_last=1, exactly 3 meta_rd pulses, no pop while meta_empty=1.
- Reset during ISSUE at idx=2 -> next cycle cmd_valid=0, busy=0, err_cnt=0; the next descriptor after reset is processed normally from idx 0.
